// File: rtl/mem_client_arbiter.sv
// Round-robin arbiter that funnels NUM_CLIENTS req/ack clients onto the single
// mem_manager port, holding each op stable until a cycle with mem_pause low completes it.
module mem_client_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CLIENTS-1:0]    client_req,
  input  logic [NUM_CLIENTS-1:0]    client_wren,
  input  logic [NUM_CLIENTS*18-1:0] client_addr,
  input  logic [NUM_CLIENTS*32-1:0] client_wdata,
  output logic [NUM_CLIENTS-1:0]    client_ack,
  output logic [31:0]               client_rdata,
  output logic                      mem_wren,
  output logic [17:0]               mem_address,
  output logic [31:0]               mem_data_write,
  input  logic                      mem_pause,
  input  logic [31:0]               mem_data_read,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic                      timeout_err
);

  // Handshake: a client raises req with its op fields and holds them until a
  // one-cycle ack; the op is latched at grant, so later input changes are ignored.
  // busy mirrors the FSM state (1 = BUSY) for external observation.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state, state_next;
  logic [7:0]             excl, req_eff;
  logic [3:0]             idx;
  logic [2:0]             rr, pick, rr_next;
  logic                   pick_valid;
  logic                   issue, complete;
  logic                   sel_wren;
  logic [17:0]            sel_addr;
  logic [31:0]            sel_wdata;
  logic [NUM_CLIENTS-1:0] ack_vec;
  logic [TIMEOUT_W-1:0]   cnt;

  // Rotating search from rr; the client being completed is excluded this edge.
  always_comb begin
    excl       = (state == BUSY) ? (8'd1 << grant_id) : 8'd0;
    req_eff    = 8'(client_req) & ~excl;
    idx        = 4'd0;
    pick       = 3'd0;
    pick_valid = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = {1'b0, rr} + 4'(k);
      if (idx >= 4'(NUM_CLIENTS)) idx = idx - 4'(NUM_CLIENTS);
      if (!pick_valid && req_eff[idx[2:0]]) begin
        pick       = idx[2:0];
        pick_valid = 1'b1;
      end
    end
    sel_wren  = 1'b0;
    sel_addr  = 18'd0;
    sel_wdata = 32'd0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick == 3'(i)) begin
        sel_wren  = client_wren[i];
        sel_addr  = client_addr[i*18 +: 18];
        sel_wdata = client_wdata[i*32 +: 32];
      end
    end
    rr_next = (pick == 3'(NUM_CLIENTS - 1)) ? 3'd0 : pick + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!mem_pause && pick_valid) state_next = BUSY;
      BUSY:    if (!mem_pause && !pick_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Any pause-free edge may issue; in BUSY that same edge also completes.
  always_comb begin
    issue    = !mem_pause && pick_valid;
    complete = (state == BUSY) && !mem_pause;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      ack_vec[i] = complete && (grant_id == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      client_ack     <= '0;
      client_rdata   <= 32'd0;
      mem_wren       <= 1'b0;
      mem_address    <= 18'd0;
      mem_data_write <= 32'd0;
      busy           <= 1'b0;
      grant_id       <= 3'd0;
      timeout_err    <= 1'b0;
      rr             <= 3'd0;
      cnt            <= '0;
    end else begin
      client_ack <= ack_vec;
      if (complete) begin
        client_rdata <= mem_data_read;
        cnt          <= '0;
      end else if (state == BUSY) begin
        if (cnt < TIMEOUT_W'(TIMEOUT_CYCLES)) cnt <= cnt + TIMEOUT_W'(1);
        if (cnt >= TIMEOUT_W'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
      end
      if (issue) begin
        mem_wren       <= sel_wren;
        mem_address    <= sel_addr;
        mem_data_write <= sel_wdata;
        grant_id       <= pick;
        rr             <= rr_next;
        busy           <= 1'b1;
      end else if (complete) begin
        mem_wren <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule
